// File: rtl/ysyx_25060170_wb_arbiter_pkg.sv
// Shared encodings for the write-back arbiter: grant source codes, default starvation limit, grant states.
// Optional perf counters are enabled by defining YSYX_25060170_WB_ARB_PERF_EN.
package ysyx_25060170_wb_arbiter_pkg;

    localparam logic [1:0] WB_SRC_NONE = 2'b00;
    localparam logic [1:0] WB_SRC_LS   = 2'b01;
    localparam logic [1:0] WB_SRC_EX   = 2'b10;

    localparam int STARVE_MAX_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GNT_LS = 2'b01,
        ST_GNT_EX = 2'b10
    } arb_state_e;

    function automatic logic [1:0] state_src(input arb_state_e st);
        case (st)
            ST_GNT_LS: state_src = WB_SRC_LS;
            ST_GNT_EX: state_src = WB_SRC_EX;
            default:   state_src = WB_SRC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_25060170_wb_arbiter_if.sv
// Retire-source handshakes and write-back port of the arbiter.
// slave = arbiter side, master = the EXU/LSU/WBU side driving it.
interface ysyx_25060170_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              ls_valid;
    logic              ls_ready;
    logic [ADDR_W-1:0] ls_rd_addr;
    logic [DATA_W-1:0] ls_data;
    logic [DATA_W-1:0] ls_pc;
    logic [DATA_W-1:0] ls_inst;

    logic              exu_valid;
    logic              exu_ready;
    logic [ADDR_W-1:0] exu_rd_addr;
    logic [DATA_W-1:0] exu_data;
    logic [DATA_W-1:0] exu_pc;
    logic [DATA_W-1:0] exu_inst;

    logic              flush;

    logic              wb_valid;
    logic              wb_rd_ena;
    logic [ADDR_W-1:0] wb_rd_addr;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] wb_pc;
    logic [DATA_W-1:0] wb_inst;
    logic [1:0]        wb_src;

    modport slave (
        input  ls_valid, ls_rd_addr, ls_data, ls_pc, ls_inst,
        input  exu_valid, exu_rd_addr, exu_data, exu_pc, exu_inst,
        input  flush,
        output ls_ready, exu_ready,
        output wb_valid, wb_rd_ena, wb_rd_addr, wb_data, wb_pc, wb_inst, wb_src
    );

    modport master (
        output ls_valid, ls_rd_addr, ls_data, ls_pc, ls_inst,
        output exu_valid, exu_rd_addr, exu_data, exu_pc, exu_inst,
        output flush,
        input  ls_ready, exu_ready,
        input  wb_valid, wb_rd_ena, wb_rd_addr, wb_data, wb_pc, wb_inst, wb_src
    );

endinterface

// File: rtl/ysyx_25060170_wb_starve_cnt.sv
// Saturating count of consecutive cycles EXU waited; at_max forces the next EXU grant.
module ysyx_25060170_wb_starve_cnt #(
    parameter int MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    input  logic flush,
    output logic at_max
);

    localparam int CW = ($clog2(MAX + 1) < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (flush || clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == MAX_C);

endmodule

// File: rtl/ysyx_25060170_wb_arbiter.sv
// LSU/EXU retire arbiter driving the register-file write port with one cycle of latency.
// Define YSYX_25060170_WB_ARB_PERF_EN to add the perf_conflict/perf_override counters.
module ysyx_25060170_wb_arbiter
    import ysyx_25060170_wb_arbiter_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst,
    ysyx_25060170_wb_arbiter_if.slave bus
`ifdef YSYX_25060170_WB_ARB_PERF_EN
    ,
    output logic [31:0] perf_conflict,
    output logic [31:0] perf_override
`endif
);

    logic ls_gnt, ex_gnt, at_max, starve_inc;

    arb_state_e        state_q, state_d;
    logic              rd_ena_q, rd_ena_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] inst_q, inst_d;

    // LSU wins by default; EXU only when alone or once starvation saturates.
    always_comb begin
        ls_gnt = 1'b0;
        ex_gnt = 1'b0;
        if (!bus.flush) begin
            if (bus.exu_valid && (!bus.ls_valid || at_max)) begin
                ex_gnt = 1'b1;
            end else if (bus.ls_valid) begin
                ls_gnt = 1'b1;
            end
        end
    end

    assign starve_inc = bus.exu_valid & ~ex_gnt & ~bus.flush;

    ysyx_25060170_wb_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (starve_inc),
        .clr    (ex_gnt),
        .flush  (bus.flush),
        .at_max (at_max)
    );

    always_comb begin
        state_d   = ST_IDLE;
        rd_ena_d  = 1'b0;
        rd_addr_d = '0;
        data_d    = '0;
        pc_d      = '0;
        inst_d    = '0;
        if (ls_gnt) begin
            state_d   = ST_GNT_LS;
            rd_ena_d  = (bus.ls_rd_addr != '0);
            rd_addr_d = bus.ls_rd_addr;
            data_d    = bus.ls_data;
            pc_d      = bus.ls_pc;
            inst_d    = bus.ls_inst;
        end else if (ex_gnt) begin
            state_d   = ST_GNT_EX;
            rd_ena_d  = (bus.exu_rd_addr != '0);
            rd_addr_d = bus.exu_rd_addr;
            data_d    = bus.exu_data;
            pc_d      = bus.exu_pc;
            inst_d    = bus.exu_inst;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rd_ena_q  <= 1'b0;
            rd_addr_q <= '0;
            data_q    <= '0;
            pc_q      <= '0;
            inst_q    <= '0;
        end else begin
            state_q   <= state_d;
            rd_ena_q  <= rd_ena_d;
            rd_addr_q <= rd_addr_d;
            data_q    <= data_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
        end
    end

    assign bus.ls_ready   = ls_gnt;
    assign bus.exu_ready  = ex_gnt;
    assign bus.wb_valid   = (state_q != ST_IDLE);
    assign bus.wb_src     = state_src(state_q);
    assign bus.wb_rd_ena  = rd_ena_q;
    assign bus.wb_rd_addr = rd_addr_q;
    assign bus.wb_data    = data_q;
    assign bus.wb_pc      = pc_q;
    assign bus.wb_inst    = inst_q;

`ifdef YSYX_25060170_WB_ARB_PERF_EN
    logic [31:0] perf_conflict_q, perf_conflict_d;
    logic [31:0] perf_override_q, perf_override_d;

    // A forced EXU grant is the only case where EXU wins while LSU is also valid.
    always_comb begin
        perf_conflict_d = perf_conflict_q;
        perf_override_d = perf_override_q;
        if (bus.ls_valid && bus.exu_valid && !bus.flush && (perf_conflict_q != '1)) begin
            perf_conflict_d = perf_conflict_q + 32'd1;
        end
        if (ex_gnt && bus.ls_valid && (perf_override_q != '1)) begin
            perf_override_d = perf_override_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_conflict_q <= '0;
            perf_override_q <= '0;
        end else begin
            perf_conflict_q <= perf_conflict_d;
            perf_override_q <= perf_override_d;
        end
    end

    assign perf_conflict = perf_conflict_q;
    assign perf_override = perf_override_q;
`endif

endmodule

// File: tb/tb_ysyx_25060170_wb_arbiter.sv
// Directed bench for the write-back arbiter: stimulus pushes expected retires, a negedge monitor pops them.
module tb_ysyx_25060170_wb_arbiter;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_LS   = 2'b01;
    localparam logic [1:0] G_EX   = 2'b10;

    logic clk;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_pass;

    ysyx_25060170_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

`ifdef YSYX_25060170_WB_ARB_PERF_EN
    logic [31:0] perf_conflict;
    logic [31:0] perf_override;
`endif

    ysyx_25060170_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef YSYX_25060170_WB_ARB_PERF_EN
        ,
        .perf_conflict (perf_conflict),
        .perf_override (perf_override)
`endif
    );

    typedef struct {
        logic [1:0]  src;
        logic        ena;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
        logic [31:0] inst;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every retire presented by the DUT must match the oldest expected grant.
    always @(negedge clk) begin
        if (rst && bus.wb_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_retire_pc", {96'd0, bus.wb_pc}, 128'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("retire_payload",
                    {24'd0, bus.wb_src, bus.wb_rd_ena, bus.wb_rd_addr, bus.wb_data, bus.wb_pc, bus.wb_inst},
                    {24'd0, e.src, e.ena, e.rd, e.data, e.pc, e.inst});
                chk("retire_cycle", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    // One arbitration cycle: inputs already driven; check readies, record the grant, advance.
    task automatic step(input logic [1:0] gnt, input string name);
        exp_t e;
        #1;
        chk({name, "_ready"}, {126'd0, bus.exu_ready, bus.ls_ready}, {126'd0, gnt});
        if (gnt == G_LS) begin
            e.src = G_LS; e.ena = (bus.ls_rd_addr != 5'd0); e.rd = bus.ls_rd_addr;
            e.data = bus.ls_data; e.pc = bus.ls_pc; e.inst = bus.ls_inst; e.cyc = cyc + 1;
            exp_q.push_back(e);
        end else if (gnt == G_EX) begin
            e.src = G_EX; e.ena = (bus.exu_rd_addr != 5'd0); e.rd = bus.exu_rd_addr;
            e.data = bus.exu_data; e.pc = bus.exu_pc; e.inst = bus.exu_inst; e.cyc = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic set_ls(input logic v, input logic [4:0] rd, input logic [31:0] data, input logic [31:0] pc);
        bus.ls_valid = v; bus.ls_rd_addr = rd; bus.ls_data = data; bus.ls_pc = pc; bus.ls_inst = pc ^ 32'h0000_0003;
    endtask

    task automatic set_ex(input logic v, input logic [4:0] rd, input logic [31:0] data, input logic [31:0] pc);
        bus.exu_valid = v; bus.exu_rd_addr = rd; bus.exu_data = data; bus.exu_pc = pc; bus.exu_inst = pc ^ 32'h0000_0013;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0;
        rst = 1'b0;
        bus.flush = 1'b0;
        set_ls(1'b0, 5'd0, 32'd0, 32'd0);
        set_ex(1'b0, 5'd0, 32'd0, 32'd0);
        #3;
        chk("reset_outputs", {64'd0, bus.wb_valid, bus.wb_rd_ena, bus.wb_src, bus.wb_rd_addr, bus.wb_data, bus.wb_pc[22:0]}, 128'd0);
        @(posedge clk); #2;
        rst = 1'b1;

        step(G_NONE, "idle0");
        step(G_NONE, "idle1");
        chk("idle_wb_valid", {127'd0, bus.wb_valid}, 128'd0);

        set_ex(1'b1, 5'd5, 32'h1234, 32'h100);
        step(G_EX, "solo_exu");
        set_ex(1'b0, 5'd0, 32'd0, 32'd0);
        step(G_NONE, "solo_exu_after");

        set_ex(1'b1, 5'd6, 32'hBEEF, 32'h104);
        for (int i = 0; i < 4; i++) begin
            set_ls(1'b1, 5'(i + 1), 32'h5000 + 32'(i), 32'h1000 + 32'(4 * i));
            step((i < 3) ? G_LS : G_EX, "conflict");
        end
`ifdef YSYX_25060170_WB_ARB_PERF_EN
        chk("perf_conflict", 128'(perf_conflict), 128'd4);
        chk("perf_override", 128'(perf_override), 128'd1);
`endif
        set_ls(1'b0, 5'd0, 32'd0, 32'd0);
        set_ex(1'b0, 5'd0, 32'd0, 32'd0);
        step(G_NONE, "conflict_after");

        set_ls(1'b1, 5'd0, 32'hFFFF, 32'h2000);
        step(G_LS, "x0_write");
        set_ls(1'b0, 5'd0, 32'd0, 32'd0);
        step(G_NONE, "x0_after");

        set_ex(1'b1, 5'd9, 32'h99, 32'h300);
        step(G_EX, "pre_reset");
        chk("pre_reset_wb_valid", {127'd0, bus.wb_valid}, 128'd1);
        rst = 1'b0;
        #1;
        chk("mid_reset_outputs", {64'd0, bus.wb_valid, bus.wb_rd_ena, bus.wb_src, bus.wb_rd_addr, bus.wb_data, bus.wb_pc[22:0]}, 128'd0);
        exp_q.delete();
        set_ex(1'b0, 5'd0, 32'd0, 32'd0);
        #1;
        rst = 1'b1;
        @(posedge clk); #2;

        set_ex(1'b1, 5'd3, 32'h3333, 32'h500);
        set_ls(1'b1, 5'd3, 32'h4000, 32'h400);
        step(G_LS, "pre_flush0");
        set_ls(1'b1, 5'd3, 32'h4001, 32'h404);
        step(G_LS, "pre_flush1");
        set_ls(1'b1, 5'd3, 32'h4002, 32'h408);
        bus.flush = 1'b1;
        step(G_NONE, "flush");
        bus.flush = 1'b0;
        chk("flush_wb_valid", {127'd0, bus.wb_valid}, 128'd0);
        for (int i = 0; i < 4; i++) begin
            set_ls(1'b1, 5'd3, 32'h4100 + 32'(i), 32'h410 + 32'(4 * i));
            step((i < 3) ? G_LS : G_EX, "post_flush");
        end

        set_ex(1'b1, 5'd7, 32'hAAAA, 32'h700);
        for (int i = 0; i < 4; i++) begin
            set_ls(1'b1, 5'd7, 32'h6000 + 32'(i), 32'h600 + 32'(4 * i));
            step((i < 3) ? G_LS : G_EX, "hold");
        end
        set_ex(1'b0, 5'd0, 32'd0, 32'd0);
        set_ls(1'b1, 5'd7, 32'h6010, 32'h640);
        step(G_LS, "hold_tail");
        set_ls(1'b0, 5'd0, 32'd0, 32'd0);
        step(G_NONE, "drain0");
        step(G_NONE, "drain1");

        chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ysyx_25060170_wb_arbiter.md
Name: ysyx_25060170_wb_arbiter

Overview:
- Arbitrates the single register-file write port between two retire sources: the LSU load-return path and the EXU result path.
- Sits between EXU/LSU and the write-back unit, and replaces the static wb_ctl mux select with a registered grant.
- Uses valid/ready handshakes, fixed LSU priority, and a starvation override for EXU.
- Drives the write-back port and the forwarding outputs seen by IDU, and emits retire PC/inst for DPI tracing.

Parameters:
- DATA_W, 32: width of write data, PC and inst.
- ADDR_W, 5: register address width.
- STARVE_MAX, 3: number of consecutive EXU-losing cycles after which EXU is forced to win.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ls_valid  in  1  LSU retire request.
- ls_ready  out  1  LSU request granted this cycle.
- ls_rd_addr  in  ADDR_W  LSU destination register.
- ls_data  in  DATA_W  LSU load data.
- ls_pc  in  DATA_W  LSU instruction PC.
- ls_inst  in  DATA_W  LSU instruction word.
- exu_valid  in  1  EXU retire request.
- exu_ready  out  1  EXU request granted this cycle.
- exu_rd_addr  in  ADDR_W  EXU destination register.
- exu_data  in  DATA_W  EXU result.
- exu_pc  in  DATA_W  EXU instruction PC.
- exu_inst  in  DATA_W  EXU instruction word.
- flush  in  1  pipeline flush (jump/trap).
- wb_valid  out  1  one instruction retires this cycle.
- wb_rd_ena  out  1  register-file write enable.
- wb_rd_addr  out  ADDR_W  write address, also the forwarding address.
- wb_data  out  DATA_W  write data, also the forwarding data.
- wb_pc  out  DATA_W  retired PC.
- wb_inst  out  DATA_W  retired instruction word.
- wb_src  out  2  grant source: 00 none, 01 LSU, 10 EXU (same encoding as wb_ctl).

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, starvation counter 0, state IDLE.
- Handshake:
  - A source holds valid and its payload stable until its ready=1.
  - ready is combinational from the valid inputs, the counter and flush.
  - At most one ready is high per cycle. Transfer happens when valid&ready.
- Grant rules, evaluated per cycle:
  - flush=1: both ready=0.
  - Only one source valid: that source is granted.
  - Both valid and starve_cnt<STARVE_MAX: LSU is granted.
  - Both valid and starve_cnt==STARVE_MAX: EXU is granted.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, on each cycle where exu_valid=1 and exu_ready=0 with flush=0.
  - Clears on EXU grant.
  - Holds when exu_valid=0.
- Output register (latency 1):
  - On a grant, the next edge loads wb_* from the granted payload and sets wb_valid=1 and wb_src.
  - wb_rd_ena = 1 only if the granted rd_addr != 0.
  - Without a grant, wb_valid, wb_rd_ena and wb_src go to 0; wb_rd_addr/wb_data/wb_pc/wb_inst clear to 0.
- State register (last grant): IDLE / GNT_LS / GNT_EX. Next state = grant of the current cycle; IDLE when no grant or flush.
- Boundaries:
  - flush has priority over everything. It clears the output register and the counter in the next cycle and drops nothing in flight: sources keep valid until their later grant or their own flush.
  - flush coincident with a grant: the grant is suppressed (ready=0).
  - Both sources targeting the same rd on back-to-back grants: each is written in its own cycle in grant order. No merging.
  - Reset asserted mid-transfer: outputs clear immediately; the payload is lost.

Optional Feature:
- Macro YSYX_25060170_WB_ARB_PERF_EN.
- When defined:
  - Adds 32-bit saturating counters perf_conflict (cycles with both valid and flush=0) and perf_override (EXU grants forced by starvation).
  - Exposes them as output ports of the same names.
  - Counters are reset by rst only.
- When undefined: the counters and ports are absent. Grant and timing behaviour is identical.

Decomposition:
- Shared define.v package holds:
  - WB_SRC_NONE/LS/EX encodings (2'b00/01/10).
  - Default STARVE_MAX.
  - The perf macro name.
- One sub-module: ysyx_25060170_wb_starve_cnt. It is a saturating counter with inc/clr/flush inputs and an at_max output.

Test Plan:
- Reset then idle: rst=0 mid-cycle → all wb_* are 0 immediately; after release with no valid, wb_valid stays 0.
- Solo EXU: exu_valid=1, rd=5, data=0x1234 → exu_ready=1 same cycle; next cycle wb_rd_ena=1, rd=5, data=0x1234, wb_src=10.
- Conflict with starvation:
  - Stimulus: both valid continuously, LSU issuing new loads each cycle.
  - Required: LSU granted in cycles 0-2; EXU granted in cycle 3.
  - Required: with PERF_EN, perf_override=1 and perf_conflict=4.
- x0 write: ls_valid=1, rd=0, data=0xFFFF → granted; next cycle wb_valid=1, wb_rd_ena=0.
- Flush during conflict: both valid plus flush=1 → both ready=0; next cycle wb_valid=0 and counter 0; the following cycle LSU is granted.
- Hold stability: EXU held 3 cycles behind LSU with a changing LSU payload → EXU payload is written exactly once with its original value; no duplicate retire of either PC.
